// File: rtl/fan_mode_ctrl.sv
// rtl/fan_mode_ctrl.sv - button conditioning and OFF/RUN frame sequencer feeding the dot-matrix scanner
// Optional auto-off timer (btn_timer/timer_on) is built only when FAN_TIMER_EN is defined.
module fan_mode_ctrl #(
  parameter int unsigned DEB_CYCLES     = 20,
  parameter int unsigned PERIOD_LOW     = 500,
  parameter int unsigned PERIOD_MID     = 250,
  parameter int unsigned PERIOD_HIGH    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_power,
  input  logic       btn_speed,
`ifdef FAN_TIMER_EN
  input  logic       btn_timer,
  output logic       timer_on,
`endif
  output logic [2:0] P,
  output logic [1:0] speed,
  output logic       running
);

  localparam int unsigned PMAX01 = (PERIOD_LOW > PERIOD_MID) ? PERIOD_LOW : PERIOD_MID;
  localparam int unsigned PMAX   = (PMAX01 > PERIOD_HIGH) ? PMAX01 : PERIOD_HIGH;
  localparam int unsigned CW     = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam int unsigned DW     = $clog2(DEB_CYCLES + 1);
`ifdef FAN_TIMER_EN
  localparam int unsigned NB     = 3;
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`else
  localparam int unsigned NB     = 2;
`endif

  typedef enum logic {S_OFF, S_RUN} state_t;

  logic [NB-1:0] btn_raw, sync1_q, sync2_q, deb_q, deb_prev_q, press;
  logic [DW-1:0] deb_cnt_q [NB];

`ifdef FAN_TIMER_EN
  assign btn_raw = {btn_timer, btn_speed, btn_power};
`else
  assign btn_raw = {btn_speed, btn_power};
`endif

  // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < int'(NB); i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < int'(NB); i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  logic pwr_ev, spd_ev;
  assign pwr_ev = press[0];
  assign spd_ev = press[1];

  state_t        state_q, state_d;
  logic [2:0]    p_q, p_d;
  logic [1:0]    speed_q, speed_d;
  logic [CW-1:0] frame_q, frame_d, period_m1;
  logic          go_off;
`ifdef FAN_TIMER_EN
  logic          tmr_ev;
  logic          timer_on_q, timer_on_d;
  logic [TW-1:0] tmr_q, tmr_d;
  assign tmr_ev = press[2];
`endif

  always_comb begin
    case (speed_q)
      2'd2:    period_m1 = CW'(PERIOD_MID - 1);
      2'd3:    period_m1 = CW'(PERIOD_HIGH - 1);
      default: period_m1 = CW'(PERIOD_LOW - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    speed_d = speed_q;
    frame_d = frame_q;
    go_off  = 1'b0;
`ifdef FAN_TIMER_EN
    timer_on_d = timer_on_q;
    tmr_d      = tmr_q;
`endif
    case (state_q)
      S_OFF: begin
        if (pwr_ev) begin
          state_d = S_RUN;
          p_d     = 3'd1;
          speed_d = 2'd1;
          frame_d = '0;
        end
      end
      S_RUN: begin
        if (frame_q == period_m1) begin
          frame_d = '0;
          p_d     = (p_q == 3'd4) ? 3'd1 : p_q + 3'd1;
        end else begin
          frame_d = frame_q + CW'(1);
        end
`ifdef FAN_TIMER_EN
        if (timer_on_q && tmr_q != '0) tmr_d = tmr_q - TW'(1);
`endif
        // Priority: power > expiry > timer > speed; a speed press suppresses that cycle's frame advance.
        if (pwr_ev) begin
          go_off = 1'b1;
`ifdef FAN_TIMER_EN
        end else if (timer_on_q && tmr_q == '0) begin
          go_off = 1'b1;
        end else if (tmr_ev) begin
          timer_on_d = ~timer_on_q;
          tmr_d      = timer_on_q ? '0 : TW'(TIMEOUT_CYCLES - 1);
`endif
        end else if (spd_ev) begin
          speed_d = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
          frame_d = '0;
          p_d     = p_q;
        end
      end
    endcase
    if (go_off) begin
      state_d = S_OFF;
      p_d     = 3'd0;
      speed_d = 2'd0;
      frame_d = '0;
`ifdef FAN_TIMER_EN
      timer_on_d = 1'b0;
      tmr_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      p_q     <= 3'd0;
      speed_q <= 2'd0;
      frame_q <= '0;
`ifdef FAN_TIMER_EN
      timer_on_q <= 1'b0;
      tmr_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      speed_q <= speed_d;
      frame_q <= frame_d;
`ifdef FAN_TIMER_EN
      timer_on_q <= timer_on_d;
      tmr_q      <= tmr_d;
`endif
    end
  end

  assign P       = p_q;
  assign speed   = speed_q;
  assign running = (state_q == S_RUN);
`ifdef FAN_TIMER_EN
  assign timer_on = timer_on_q;
`endif

endmodule

// File: tb/tb_fan_mode_ctrl.sv
// tb/tb_fan_mode_ctrl.sv - table-driven bench for fan_mode_ctrl
module tb_fan_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_power;
  logic       btn_speed;
  logic [2:0] P;
  logic [1:0] speed;
  logic       running;
`ifdef FAN_TIMER_EN
  logic       btn_timer;
  logic       timer_on;
`endif

  fan_mode_ctrl #(
    .DEB_CYCLES(4), .PERIOD_LOW(8), .PERIOD_MID(4), .PERIOD_HIGH(2), .TIMEOUT_CYCLES(40)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_power(btn_power),
    .btn_speed(btn_speed),
`ifdef FAN_TIMER_EN
    .btn_timer(btn_timer),
    .timer_on(timer_on),
`endif
    .P(P),
    .speed(speed),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pwr;
    logic       spd;
    int         n;
    logic [2:0] p;
    logic [1:0] s;
    logic       r;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic pwr, input logic spd, input int n,
                     input logic [2:0] p, input logic [1:0] s, input logic r);
    vec_t v;
    v.pwr = pwr; v.spd = spd; v.n = n; v.p = p; v.s = s; v.r = r;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int p, input int s, input int r);
    chk({tag, ".P"}, int'(P), p);
    chk({tag, ".speed"}, int'(speed), s);
    chk({tag, ".running"}, int'(running), r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      btn_power = vecs[i].pwr;
      btn_speed = vecs[i].spd;
      step(vecs[i].n);
      chk_out($sformatf("row%0d", i), int'(vecs[i].p), int'(vecs[i].s), int'(vecs[i].r));
    end
  endtask

  int part1_end;

  initial begin
    // Bounce: power toggling every 2 cycles must never produce an event.
    for (int k = 0; k < 16; k++) add((k % 2) == 0, 1'b0, 2, 3'd0, 2'd0, 1'b0);
    add(0, 0, 10, 0, 0, 0);
    // Clean power press: outputs change exactly 7 cycles after press start; period 8.
    add(1, 0, 6, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1);
    add(1, 0, 3, 1, 1, 1);
    add(0, 0, 4, 1, 1, 1);
    add(0, 0, 1, 2, 1, 1);
    add(0, 0, 8, 3, 1, 1);
    add(0, 0, 8, 4, 1, 1);
    add(0, 0, 8, 1, 1, 1);
    add(0, 0, 7, 1, 1, 1);
    add(0, 0, 1, 2, 1, 1);
    // Speed 1 -> 2, period 4.
    add(0, 1, 6, 2, 1, 1);
    add(0, 1, 1, 2, 2, 1);
    add(0, 0, 3, 2, 2, 1);
    add(0, 0, 1, 3, 2, 1);
    add(0, 0, 4, 4, 2, 1);
    add(0, 0, 1, 4, 2, 1);
    // Speed 2 -> 3 landing on a frame wrap: P must not advance.
    add(0, 1, 3, 1, 2, 1);
    add(0, 1, 4, 1, 3, 1);
    add(0, 0, 1, 1, 3, 1);
    add(0, 0, 1, 2, 3, 1);
    add(0, 0, 2, 3, 3, 1);
    add(0, 0, 4, 1, 3, 1);
    // Speed 3 -> 1, period 8.
    add(0, 1, 6, 4, 3, 1);
    add(0, 1, 1, 4, 1, 1);
    add(0, 0, 7, 4, 1, 1);
    add(0, 0, 1, 1, 1, 1);
    // To speed 2, then simultaneous power+speed turns off.
    add(0, 1, 7, 1, 2, 1);
    add(0, 0, 8, 3, 2, 1);
    add(1, 1, 6, 4, 2, 1);
    add(1, 1, 1, 0, 0, 0);
    add(0, 0, 8, 0, 0, 0);
    // Restart at speed 1, P=1; run on to P=3 for the reset test.
    add(1, 0, 7, 1, 1, 1);
    add(0, 0, 7, 1, 1, 1);
    add(0, 0, 1, 2, 1, 1);
    add(0, 0, 8, 3, 1, 1);
    part1_end = vecs.size();
    // After reset: idle, a 3-cycle glitch (rejected), then a 4-cycle press (accepted).
    add(0, 0, 20, 0, 0, 0);
    add(1, 0, 3, 0, 0, 0);
    add(0, 0, 10, 0, 0, 0);
    add(1, 0, 4, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0);
    add(0, 0, 1, 1, 1, 1);
    add(0, 0, 5, 1, 1, 1);

    btn_power = 1'b0;
    btn_speed = 1'b0;
`ifdef FAN_TIMER_EN
    btn_timer = 1'b0;
`endif
    rst_n = 1'b0;
    #23;
    chk_out("reset", 0, 0, 0);
`ifdef FAN_TIMER_EN
    chk("reset.timer_on", int'(timer_on), 0);
`endif
    rst_n = 1'b1;
    step(1);

    run_rows(0, part1_end);

    // Asynchronous reset with P=3: outputs clear before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", 0, 0, 0);
    step(1);
    chk_out("reset_held", 0, 0, 0);
    #2 rst_n = 1'b1;

    run_rows(part1_end, vecs.size());

`ifdef FAN_TIMER_EN
    btn_timer = 1'b1;
    step(6);
    chk("timer_pre", int'(timer_on), 0);
    step(1);
    chk("timer_armed", int'(timer_on), 1);
    btn_timer = 1'b0;
    step(39);
    chk("timer_last_run", int'(running), 1);
    chk("timer_last_on", int'(timer_on), 1);
    step(1);
    chk_out("timer_expired", 0, 0, 0);
    chk("timer_expired.timer_on", int'(timer_on), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
